menu_input_ctrl: RTL

Front-end input block that generates the `enter` and `value` signals consumed by the Pong game-flow FSM. It synchronizes and debounces the raw joystick button and up/down contacts, and produces a clean level `enter`. It also runs the pause-menu cursor that decides `value` (Continue vs Restart). It sits between the board pins and the game-flow FSM and reads that FSM's `enable_start` / `enable_pause` outputs back to know which menu is active.

---
 rtl/pong_pkg.sv | 29 ++
 rtl/input_debouncer.sv | 56 +++++
 rtl/menu_input_ctrl.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/pong_pkg.sv
// Shared encodings for the Pong menu input block and the game-flow FSM.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pong_pkg;

  // Pause-menu selection as seen on the value output
  localparam logic VALUE_CONTINUE = 1'b0;
  localparam logic VALUE_RESTART  = 1'b1;

  // Pause-menu cursor state
  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    CONTINUE = 2'b01,
    RESTART  = 2'b10
  } cursor_state_t;

  // Game-flow FSM states, shared so both ends of the enable_* handshake agree
  typedef enum logic [1:0] {
    START = 2'b00,
    GAME  = 2'b01,
    PAUSE = 2'b10
  } game_state_t;

  // Width of a counter that must be able to hold the value 'cycles'
  function automatic int debounce_cnt_width(input int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/input_debouncer.sv
// Two-flop synchronizer followed by a counter-based debouncer for one raw contact.
// Latency: stable follows a steady raw change DEBOUNCE_CYCLES+2 edges after the first sampling edge.
// Backpressure: none; free-running.
// Ports:
//   clock  - rising-edge clock
//   reset  - synchronous, active-low
//   raw    - asynchronous contact input, active-high
//   sample - synchronized (undebounced) level
//   stable - debounced level
module input_debouncer
  import pong_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic sample,
  output logic stable
);

  localparam int CNT_W = debounce_cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             sync_q1;
  logic             sync_q2;
  logic             stable_q;
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      sync_q1  <= 1'b0;
      sync_q2  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync_q1 <= raw;
      sync_q2 <= sync_q1;
      if (sync_q2 == stable_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        // This edge accepts the DEBOUNCE_CYCLES-th consecutive differing
        // sample: the count has reached its limit, so flip and restart.
        stable_q <= ~stable_q;
        cnt_q    <= '0;
      end else begin
        cnt_q <= cnt_q + CNT_ONE;
      end
    end
  end

  assign sample = sync_q2;
  assign stable = stable_q;

endmodule

// File: rtl/menu_input_ctrl.sv
// Debounced enter level and pause-menu cursor (Continue/Restart) for the game-flow FSM.
// Latency: enter DEBOUNCE_CYCLES+2 edges after raw button change; value DEBOUNCE_CYCLES+3 after up/down.
// Backpressure: none; the cursor freezes while enter is high so value is stable across a press.
// Ports:
//   clock, reset                 - rising-edge clock, synchronous active-low reset
//   btn_raw, up_raw, down_raw    - asynchronous joystick contacts, active-high
//   enable_start, enable_pause   - menu-visible flags from the game-flow FSM
//   enter                        - debounced, armed button level
//   value                        - 0 = Continue, 1 = Restart; 0 while enable_pause is low
//   cursor_valid                 - registered OR of enable_start/enable_pause
module menu_input_ctrl
  import pong_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic btn_raw,
  input  logic up_raw,
  input  logic down_raw,
  input  logic enable_start,
  input  logic enable_pause,
  output logic enter,
  output logic value,
  output logic cursor_valid
);

  localparam int CNT_W = debounce_cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic btn_sample;
  logic btn_stable;
  logic up_sample;
  logic up_stable;
  logic down_sample;
  logic down_stable;

  input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_db (
    .clock  (clock),
    .reset  (reset),
    .raw    (btn_raw),
    .sample (btn_sample),
    .stable (btn_stable)
  );

  input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up_db (
    .clock  (clock),
    .reset  (reset),
    .raw    (up_raw),
    .sample (up_sample),
    .stable (up_stable)
  );

  input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_down_db (
    .clock  (clock),
    .reset  (reset),
    .raw    (down_raw),
    .sample (down_sample),
    .stable (down_stable)
  );

  // Only the button's synchronized sample is needed (for arming)
  logic unused_samples;
  assign unused_samples = up_sample ^ down_sample;

  // ---------------------------------------------------------------------------
  // Arm flag. The debounced level resets to 0, so "low" right after reset
  // proves nothing about a button held through reset. Arming therefore needs
  // DEBOUNCE_CYCLES consecutive genuinely-low synchronized samples, i.e. the
  // button has actually been seen released for a full debounce window.
  // ---------------------------------------------------------------------------
  logic             arm_q;
  logic [CNT_W-1:0] arm_cnt_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      arm_q     <= 1'b0;
      arm_cnt_q <= '0;
    end else if (!arm_q) begin
      if (btn_sample) begin
        arm_cnt_q <= '0;
      end else if (arm_cnt_q == CNT_LAST) begin
        arm_q <= 1'b1;
      end else begin
        arm_cnt_q <= arm_cnt_q + CNT_ONE;
      end
    end
  end

  assign enter = btn_stable & arm_q;

  // ---------------------------------------------------------------------------
  // Rising-edge pulses of the debounced up/down levels
  // ---------------------------------------------------------------------------
  logic up_stable_d;
  logic down_stable_d;
  logic up_pulse;
  logic down_pulse;

  always_ff @(posedge clock) begin
    if (!reset) begin
      up_stable_d   <= 1'b0;
      down_stable_d <= 1'b0;
    end else begin
      up_stable_d   <= up_stable;
      down_stable_d <= down_stable;
    end
  end

  assign up_pulse   = up_stable & ~up_stable_d;
  assign down_pulse = down_stable & ~down_stable_d;

  // ---------------------------------------------------------------------------
  // Cursor FSM
  // ---------------------------------------------------------------------------
  cursor_state_t state_q;
  cursor_state_t state_d;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    // Leaving the pause menu beats any cursor move in the same cycle
    if (!enable_pause) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          // Every entry into the pause menu starts on Continue
          state_d = CONTINUE;
        end
        CONTINUE: begin
          // Frozen while enter is high; simultaneous up+down is ambiguous
          if (!enter && down_pulse && !up_pulse) begin
            state_d = RESTART;
          end
        end
        RESTART: begin
          if (!enter && up_pulse && !down_pulse) begin
            state_d = CONTINUE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Gated by enable_pause so value is 0 in the very cycle the menu closes
  assign value = (enable_pause && (state_q == RESTART)) ? VALUE_RESTART
                                                        : VALUE_CONTINUE;

  // ---------------------------------------------------------------------------
  // Highlight-valid flag for the renderer
  // ---------------------------------------------------------------------------
  logic cursor_valid_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      cursor_valid_q <= 1'b0;
    end else begin
      cursor_valid_q <= enable_start | enable_pause;
    end
  end

  assign cursor_valid = cursor_valid_q;

endmodule
